// File: rtl/mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_access_unit
//
// MEM-stage load/store engine. Takes the registered load/store from the EX/MEM
// pipeline register, checks alignment and encoding, and either issues a single
// valid/ready request on the data-memory port or raises a one-cycle
// misaligned/illegal exception. Load responses are shifted down to byte 0 and
// sign- or zero-extended. The rest of the pipeline is held while an access is
// in flight.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   MEM_memory_read       load present in MEM
//   MEM_memory_write      store present in MEM (wins over read)
//   MEM_funct3            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   MEM_alu_result        effective byte address
//   MEM_read_data2        store data
//   dmem_req_*            request channel (valid/ready)
//   dmem_resp_valid/rdata read response (no back-pressure)
//   mem_stall             hold IF..MEM stages
//   load_data             aligned, extended load result (held until next load)
//   load_data_valid       one-cycle pulse when a load completes
//   misaligned_exception  one-cycle pulse when an access is rejected
//   misaligned_addr       offending byte address (valid with the pulse)
//   dbg_state             current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_stage_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MEM_memory_read,
  input  logic            MEM_memory_write,
  input  logic [2:0]      MEM_funct3,
  input  logic [XLEN-1:0] MEM_alu_result,
  input  logic [XLEN-1:0] MEM_read_data2,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_write,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [3:0]      dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_data_valid,
  output logic            misaligned_exception,
  output logic [XLEN-1:0] misaligned_addr,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_DONE      = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [XLEN-1:0]   r_addr;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_wstrb;
  logic [XLEN-1:0]   r_load_data;

  logic              w_access;
  logic              w_illegal;
  logic [XLEN-1:0]   w_wdata;
  logic [3:0]        w_wstrb;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_load_ext;

  // A store takes priority when both flags are set, so "access" is the OR and
  // the direction is simply the write flag.
  assign w_access = MEM_memory_read | MEM_memory_write;

  // Legality of the access currently presented by EX/MEM.
  always_comb begin
    w_illegal = 1'b0;
    case (MEM_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = MEM_alu_result[0];
      3'b010:  w_illegal = (MEM_alu_result[1:0] != 2'b00);
      3'b100:  w_illegal = MEM_memory_write;
      3'b101:  w_illegal = MEM_memory_write | MEM_alu_result[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Store lane placement: data is replicated across lanes so the byte strobe
  // alone selects the target bytes. Loads carry an all-zero strobe.
  always_comb begin
    w_wdata = MEM_read_data2;
    w_wstrb = 4'b0000;
    if (MEM_memory_write) begin
      case (MEM_funct3[1:0])
        2'b00: begin
          w_wdata = {4{MEM_read_data2[7:0]}};
          w_wstrb = 4'b0001 << MEM_alu_result[1:0];
        end
        2'b01: begin
          w_wdata = {2{MEM_read_data2[15:0]}};
          w_wstrb = 4'b0011 << MEM_alu_result[1:0];
        end
        default: begin
          w_wdata = MEM_read_data2;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Load alignment: bring the addressed byte/halfword down to bit 0, then
  // extend according to the latched funct3.
  assign w_shifted = dmem_resp_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_funct3)
      3'b000:  w_load_ext = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_load_ext = dmem_resp_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // Handshake: a request transfers in the cycle where dmem_req_valid and
  // dmem_req_ready are both high; once valid rises every request field stays
  // constant until that cycle, and valid never drops before it. The response
  // channel has no ready: dmem_resp_valid is consumed only in WAIT_RESP.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_next_state = w_illegal ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          w_next_state = r_write ? S_DONE : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (dmem_resp_valid) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_FAULT: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: request fields are captured once in IDLE and held
  // through REQ; load data only changes on a response seen in WAIT_RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_funct3    <= 3'b000;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= 4'b0000;
      r_load_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_access) begin
        r_addr   <= MEM_alu_result;
        r_funct3 <= MEM_funct3;
        r_write  <= MEM_memory_write;
        r_wdata  <= w_wdata;
        r_wstrb  <= w_wstrb;
      end
      if (r_state == S_WAIT_RESP && dmem_resp_valid) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dmem_req_valid       = 1'b0;
    mem_stall            = 1'b0;
    load_data_valid      = 1'b0;
    misaligned_exception = 1'b0;
    misaligned_addr      = '0;
    case (r_state)
      S_IDLE:      mem_stall = w_access;
      S_REQ: begin
        dmem_req_valid = 1'b1;
        mem_stall      = 1'b1;
      end
      S_WAIT_RESP: mem_stall = 1'b1;
      S_DONE:      load_data_valid = ~r_write;
      S_FAULT: begin
        misaligned_exception = 1'b1;
        misaligned_addr      = r_addr;
      end
      default: begin
        dmem_req_valid = 1'b0;
      end
    endcase
  end

  assign dmem_req_write = r_write;
  assign dmem_req_addr  = {r_addr[XLEN-1:2], 2'b00};
  assign dmem_req_wdata = r_wdata;
  assign dmem_req_wstrb = r_wstrb;
  assign load_data      = r_load_data;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access_unit
//
// Directed bench for mem_stage_access_unit. Inputs change 1 ns after each
// rising edge; outputs are sampled on the falling edge. Expected load results
// are hand-computed constants pushed into exp_q and consumed by a monitor on
// each load_data_valid pulse.
// -----------------------------------------------------------------------------
module tb_mem_stage_access_unit;

  localparam int XLEN = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic            clk;
  logic            reset;
  logic            mem_memory_read;
  logic            mem_memory_write;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_read_data2;
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_write;
  logic [XLEN-1:0] dmem_req_addr;
  logic [XLEN-1:0] dmem_req_wdata;
  logic [3:0]      dmem_req_wstrb;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_rdata;
  logic            mem_stall;
  logic [XLEN-1:0] load_data;
  logic            load_data_valid;
  logic            misaligned_exception;
  logic [XLEN-1:0] misaligned_addr;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0] exp_q[$];

  mem_stage_access_unit #(.XLEN(XLEN)) dut (
    .clk                  (clk),
    .reset                (reset),
    .MEM_memory_read      (mem_memory_read),
    .MEM_memory_write     (mem_memory_write),
    .MEM_funct3           (mem_funct3),
    .MEM_alu_result       (mem_alu_result),
    .MEM_read_data2       (mem_read_data2),
    .dmem_req_valid       (dmem_req_valid),
    .dmem_req_ready       (dmem_req_ready),
    .dmem_req_write       (dmem_req_write),
    .dmem_req_addr        (dmem_req_addr),
    .dmem_req_wdata       (dmem_req_wdata),
    .dmem_req_wstrb       (dmem_req_wstrb),
    .dmem_resp_valid      (dmem_resp_valid),
    .dmem_resp_rdata      (dmem_resp_rdata),
    .mem_stall            (mem_stall),
    .load_data            (load_data),
    .load_data_valid      (load_data_valid),
    .misaligned_exception (misaligned_exception),
    .misaligned_addr      (misaligned_addr),
    .dbg_state            (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every load completion must match the oldest expected value.
  always @(negedge clk) begin
    if (!reset && load_data_valid) begin
      if (exp_q.size() == 0) begin
        chk("ldv_spurious", 32'd1, 32'd0);
      end else begin
        chk("sb_load_data", load_data, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_memory_read  = 1'b0;
    mem_memory_write = 1'b0;
    mem_funct3       = 3'b000;
    mem_alu_result   = '0;
    mem_read_data2   = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    mem_memory_read  = rd;
    mem_memory_write = wr;
    mem_funct3       = f3;
    mem_alu_result   = addr;
    mem_read_data2   = data;
  endtask

  // One legal access end to end. ready_lat = cycles in REQ with ready low
  // before the handshake cycle. Loads get their response one cycle after
  // acceptance.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int ready_lat, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_load);
    step();
    drive(rd, wr, f3, addr, data);
    @(negedge clk);
    chk("idle_stall", {31'd0, mem_stall}, 32'd1);
    chk("idle_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    for (int k = 0; k <= ready_lat; k++) begin
      step();
      dmem_req_ready = (k == ready_lat);
      @(negedge clk);
      chk("req_state", {29'd0, dbg_state}, {29'd0, ST_REQ});
      chk("req_valid", {31'd0, dmem_req_valid}, 32'd1);
      chk("req_addr", dmem_req_addr, exp_addr);
      chk("req_wstrb", {28'd0, dmem_req_wstrb}, {28'd0, exp_wstrb});
      chk("req_write", {31'd0, dmem_req_write}, {31'd0, wr});
      chk("req_stall", {31'd0, mem_stall}, 32'd1);
      if (wr) chk("req_wdata", dmem_req_wdata, exp_wdata);
    end
    step();
    dmem_req_ready = 1'b0;
    if (!wr) begin
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = rdata;
      exp_q.push_back(exp_load);
      @(negedge clk);
      chk("wait_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
      chk("wait_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("wait_stall", {31'd0, mem_stall}, 32'd1);
      step();
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    chk("done_state", {29'd0, dbg_state}, {29'd0, ST_DONE});
    chk("done_stall", {31'd0, mem_stall}, 32'd0);
    chk("done_ldv", {31'd0, load_data_valid}, {31'd0, ~wr});
    chk("done_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    step();
    clear_inputs();
    @(negedge clk);
    chk("after_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("after_stall", {31'd0, mem_stall}, 32'd0);
    if (!wr) chk("load_hold", load_data, exp_load);
  endtask

  // An access that must be rejected without touching the memory port.
  task automatic fault(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr);
    step();
    drive(rd, wr, f3, addr, 32'h1234_5678);
    @(negedge clk);
    chk("flt_idle_stall", {31'd0, mem_stall}, 32'd1);
    chk("flt_idle_exc", {31'd0, misaligned_exception}, 32'd0);
    chk("flt_idle_valid", {31'd0, dmem_req_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("flt_state", {29'd0, dbg_state}, {29'd0, ST_FAULT});
    chk("flt_exc", {31'd0, misaligned_exception}, 32'd1);
    chk("flt_addr", misaligned_addr, addr);
    chk("flt_stall", {31'd0, mem_stall}, 32'd0);
    chk("flt_valid", {31'd0, dmem_req_valid}, 32'd0);
    step();
    clear_inputs();
    @(negedge clk);
    chk("flt_after_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("flt_after_exc", {31'd0, misaligned_exception}, 32'd0);
    chk("flt_after_valid", {31'd0, dmem_req_valid}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset           = 1'b1;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = '0;
    clear_inputs();
    repeat (3) step();
    @(negedge clk);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_ldv", {31'd0, load_data_valid}, 32'd0);
    chk("rst_exc", {31'd0, misaligned_exception}, 32'd0);
    step();
    reset = 1'b0;

    // Stores:        rd    wr    f3      addr          data          lat rdata  exp_addr      exp_wdata     wstrb    load
    access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_5678, 0, 32'h0, 32'h0000_0100, 32'h5678_5678, 4'b1100, 32'h0);
    access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_003C, 1, 32'h0, 32'h0000_0100, 32'h3C3C_3C3C, 4'b0010, 32'h0);
    // Read and write both set: the store wins.
    access(1'b1, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 0, 32'h0, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 32'h0);

    // Loads
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 32'h0000_0100, 32'h0, 4'b0000, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 32'h0000_0100, 32'h0, 4'b0000, 32'h0000_0080);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 32'h0000_0100, 32'h0, 4'b0000, 32'hFFFF_80FF);
    access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 32'h0000_0100, 32'h0, 4'b0000, 32'h0000_80FF);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 32'h80FF_1234, 32'h0000_0100, 32'h0, 4'b0000, 32'h0000_0012);
    // Back-pressure: ready low for three REQ cycles, handshake on the fourth.
    access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 3, 32'h1357_9BDF, 32'h0000_0200, 32'h0, 4'b0000, 32'h1357_9BDF);

    // Rejected accesses
    fault(1'b1, 1'b0, 3'b010, 32'h0000_0102);   // LW misaligned
    fault(1'b1, 1'b0, 3'b001, 32'h0000_0101);   // LH odd address
    fault(1'b1, 1'b0, 3'b101, 32'h0000_0103);   // LHU odd address
    fault(1'b0, 1'b1, 3'b100, 32'h0000_0100);   // store with BU encoding
    fault(1'b1, 1'b0, 3'b011, 32'h0000_0100);   // reserved funct3
    fault(1'b0, 1'b1, 3'b010, 32'h0000_0106);   // SW misaligned

    // Reset while waiting for a load response; the late response is ignored.
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    dmem_req_ready = 1'b1;
    step();                       // REQ, handshake
    step();                       // WAIT_RESP
    dmem_req_ready = 1'b0;
    reset          = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rw_wait_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    step();                       // reset taken
    reset           = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hFEED_FACE;
    @(negedge clk);
    chk("rw_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rw_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rw_ldv", {31'd0, load_data_valid}, 32'd0);
    step();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rw_load_data", load_data, 32'd0);
    chk("rw_ldv2", {31'd0, load_data_valid}, 32'd0);
    chk("rw_state2", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Normal operation after the reset.
    access(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234, 32'h0000_0100, 32'h0, 4'b0000, 32'hFFFF_FFFF);

    repeat (3) step();
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
